// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end and decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt,
    StFault
  } fetch_state_e;

  // beq x0,x0,#0: the program's terminating self-loop.
  localparam logic [31:0] HALT_INSN = 32'h00000063;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  function automatic logic [6:0] insn_opcode(logic [31:0] insn);
    return insn[6:0];
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register between fetch and decode; flush overrides load.
module fetch_out_reg #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the byte PC, fetches from a zero-latency instruction memory, applies
// execute redirects, detects the halt self-loop and counts issued instructions.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W    = 6,
  parameter int unsigned       PC_W      = ADDR_W + 2,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       HALT_INSN = fetch_pkg::HALT_INSN,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              id_ready,
  input  logic [31:0]       i_mem_data,
  output logic [ADDR_W-1:0] i_mem_addr,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [PC_W-1:0]   id_pc,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  issued_cnt
);

  import fetch_pkg::*;

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;
  logic             out_load, out_flush;
  logic             handshake;

  assign handshake = id_valid && id_ready;

  // Redirect beats halt detection, which beats fetch/stall.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    out_load  = 1'b0;
    out_flush = 1'b0;
    cnt_d     = cnt_q + CNT_W'(handshake);
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (redirect_valid) begin
          out_flush = 1'b1;
          if (redirect_pc[1:0] != 2'b00) begin
            state_d = StFault;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (handshake && (id_instr == HALT_INSN)) begin
          out_flush = 1'b1;
          state_d   = StHalt;
        end else if (!id_valid || id_ready) begin
          out_load = 1'b1;
          pc_d     = pc_q + PC_W'(4);
        end
      end
      StHalt, StFault: begin
        // Terminal until reset.
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    halted_d = (state_d == StHalt);
    fault_d  = (state_d == StFault);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  fetch_out_reg #(
    .PC_W (PC_W)
  ) u_out_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (out_load),
    .flush_i (out_flush),
    .instr_i (i_mem_data),
    .pc_i    (pc_q),
    .valid_o (id_valid),
    .instr_o (id_instr),
    .pc_o    (id_pc)
  );

  assign i_mem_addr = pc_q[PC_W-1:2];
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against a cycle-level behavioural model.
module tb_fetch_sequencer;

  localparam logic [31:0] HALT_W = 32'h00000063;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;
  localparam int M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst, start, redirect_valid, id_ready;
  logic [7:0]  redirect_pc;
  logic [31:0] i_mem_data;
  logic [5:0]  i_mem_addr;
  logic        id_valid, halted, fault;
  logic [31:0] id_instr;
  logic [7:0]  id_pc, pc;
  logic [15:0] issued_cnt;

  logic [31:0] mem [64];
  assign i_mem_data = mem[i_mem_addr];

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .i_mem_data     (i_mem_data),
    .i_mem_addr     (i_mem_addr),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .pc             (pc),
    .halted         (halted),
    .fault          (fault),
    .issued_cnt     (issued_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_mode, m_pc, m_idpc, m_cnt;
  bit          m_valid;
  logic [31:0] m_instr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by the stated rules, then compare.
  task automatic step(input bit r, input bit s, input bit rv, input int rpc, input bit rdy);
    bit hs;
    rst = r; start = s; redirect_valid = rv; redirect_pc = rpc[7:0]; id_ready = rdy;
    if (r) begin
      m_mode = M_IDLE; m_pc = 0; m_valid = 0; m_instr = '0; m_idpc = 0; m_cnt = 0;
    end else if (m_mode == M_IDLE) begin
      if (s) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      hs = m_valid && rdy;
      if (hs) m_cnt = (m_cnt + 1) % 65536;
      if (rv) begin
        m_valid = 0;
        if (rpc % 4 != 0) m_mode = M_FAULT;
        else m_pc = rpc % 256;
      end else if (hs && m_instr == HALT_W) begin
        m_mode  = M_HALT;
        m_valid = 0;
      end else if (!m_valid || rdy) begin
        m_instr = mem[m_pc / 4];
        m_idpc  = m_pc;
        m_valid = 1;
        m_pc    = (m_pc + 4) % 256;
      end
    end
    @(posedge clk);
    #1;
    check_eq("id_valid", id_valid, m_valid);
    check_eq("pc", pc, m_pc);
    check_eq("i_mem_addr", i_mem_addr, m_pc / 4);
    check_eq("halted", halted, m_mode == M_HALT);
    check_eq("fault", fault, m_mode == M_FAULT);
    check_eq("issued_cnt", issued_cnt, m_cnt);
    if (m_valid || r) begin
      check_eq("id_pc", id_pc, m_idpc);
      check_eq("id_instr", id_instr, m_instr);
    end
  endtask

  initial begin
    int stuck;
    bit r, s, rv, rdy;
    int rpc;
    for (int k = 0; k < 64; k++) mem[k] = k + 1;
    mem[14] = HALT_W;
    rst = 1; start = 0; redirect_valid = 0; redirect_pc = '0; id_ready = 0;

    // Reset and sequential fetch
    step(1, 0, 0, 0, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_valid", id_valid, 0);
    step(0, 1, 0, 0, 1);
    check_eq("idle_no_fetch", id_valid, 0);
    step(0, 0, 0, 0, 1);
    check_eq("first_pc", id_pc, 0);
    check_eq("first_instr", id_instr, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_eq("third_instr", id_instr, 3);

    // Stall at id_pc=8
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    check_eq("stall_idpc", id_pc, 8);
    check_eq("stall_pc", pc, 12);
    check_eq("stall_cnt", issued_cnt, 2);
    step(0, 0, 0, 0, 1);
    check_eq("release_idpc", id_pc, 12);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    check_eq("at_24", id_pc, 24);

    // Redirect while stalled
    step(0, 0, 1, 36, 0);
    check_eq("redir_flush", id_valid, 0);
    check_eq("redir_pc", pc, 36);
    check_eq("redir_cnt", issued_cnt, 6);
    step(0, 0, 0, 0, 1);
    check_eq("redir_target", id_pc, 36);

    // Run into the halt word at 56
    step(0, 0, 1, 52, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_eq("halt_word", id_instr, HALT_W);
    step(0, 0, 0, 0, 1);
    check_eq("halted", halted, 1);
    check_eq("halt_cnt", issued_cnt, 9);
    step(0, 1, 1, 8, 1);
    check_eq("halt_sticky", halted, 1);

    // Redirect alongside the halt handshake wins
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 56, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 8, 1);
    check_eq("halt_vs_redir", halted, 0);
    check_eq("halt_vs_redir_pc", pc, 8);
    check_eq("halt_vs_redir_cnt", issued_cnt, 1);
    step(0, 0, 0, 0, 1);

    // PC wrap
    step(0, 0, 1, 252, 1);
    step(0, 0, 0, 0, 1);
    check_eq("wrap_idpc", id_pc, 252);
    check_eq("wrap_pc", pc, 0);
    step(0, 0, 0, 0, 1);
    check_eq("wrap_instr", id_instr, 1);

    // Misaligned redirect faults; start/redirect then ignored
    step(0, 0, 1, 'h22, 1);
    check_eq("fault", fault, 1);
    check_eq("fault_pc", pc, 4);
    step(0, 1, 1, 8, 1);
    check_eq("fault_sticky_pc", pc, 4);
    step(1, 0, 0, 0, 0);
    check_eq("fault_cleared", fault, 0);

    // Reset mid-stall
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_eq("midrst_cnt", issued_cnt, 0);
    step(0, 0, 0, 0, 1);
    check_eq("idle_until_start", id_valid, 0);

    // Randomized traffic
    stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      mem[$urandom_range(0, 63)] = ($urandom % 8 == 0) ? HALT_W : $urandom;
      stuck = (m_mode == M_HALT || m_mode == M_FAULT) ? stuck + 1 : 0;
      r   = ($urandom % 150 == 0) || (stuck > 15);
      s   = ($urandom % 6 == 0);
      rv  = ($urandom % 12 == 0);
      rpc = ($urandom % 6 == 0) ? int'($urandom_range(0, 255)) : 4 * int'($urandom_range(0, 63));
      rdy = ($urandom % 10 < 7);
      step(r, s, rv, rpc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the 64-word combinational instruction memory for the single-cycle/pipelined processor.
- Owns the byte PC and drives the memory's word address from it.
- Registers each fetched instruction into a valid/ready stage toward decode.
- Applies branch/jump redirects from execute, detects the self-loop halt idiom, and counts issued instructions.

Parameters:
- ADDR_W, 6: instruction memory word-address width (2^ADDR_W words).
- PC_W, ADDR_W+2: byte PC width.
- RESET_PC, 0: byte PC loaded at reset.
- HALT_INSN, 32'h00000063: encoding of beq x0,x0,#0, the program-terminating self-loop.
- CNT_W, 16: issued-instruction counter width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; leaves IDLE.
- redirect_valid  in  1  execute reports a taken branch/jump this cycle.
- redirect_pc  in  PC_W  byte target of the redirect.
- id_ready  in  1  decode can accept the output instruction.
- i_mem_data  in  32  instruction word returned combinationally by memory.
- i_mem_addr  out  ADDR_W  word address to memory, equal to pc[PC_W-1:2].
- id_valid  out  1  id_instr/id_pc hold a valid instruction.
- id_instr  out  32  fetched instruction.
- id_pc  out  PC_W  byte address of id_instr.
- pc  out  PC_W  next byte address to be fetched.
- halted  out  1  HALT state.
- fault  out  1  FAULT state (misaligned redirect).
- issued_cnt  out  CNT_W  count of id_valid&&id_ready handshakes.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, halted=0, fault=0, issued_cnt=0. Reset in any state, mid-stall or mid-redirect, returns here in one cycle.
- i_mem_addr is combinational from pc in all states; memory read has zero latency.
- States:
  - IDLE: no fetch, id_valid=0. start -> RUN. redirect ignored.
  - RUN: fetch enabled. Register load condition is load = !id_valid || id_ready. On load: id_instr<=i_mem_data, id_pc<=pc, id_valid<=1, pc<=pc+4.
  - HALT: no fetch, id_valid=0, halted=1. Exit only via rst.
  - FAULT: no fetch, id_valid=0, fault=1. Exit only via rst.
- Stall: id_valid && !id_ready holds id_instr, id_pc and pc stable. The output is never overwritten while unaccepted.
- Redirect (RUN only) has priority over fetch and stall:
  - if redirect_pc[1:0]!=0 -> FAULT next cycle, id_valid<=0, pc unchanged.
  - else pc<=redirect_pc and id_valid<=0 (flush the wrong-path instruction). The fetch at redirect_pc occurs the following cycle.
  - A handshake in the same cycle still counts in issued_cnt.
- Halt: a handshake (id_valid && id_ready) with id_instr==HALT_INSN counts, then -> HALT next cycle, id_valid<=0. A simultaneous valid redirect takes precedence; no halt in that case.
- PC arithmetic is modulo 2^PC_W: pc=252 (ADDR_W=6) +4 -> 0. The same wrap applies to redirect targets.
- issued_cnt increments on each handshake, wraps at 2^CNT_W.
- start while in RUN/HALT/FAULT is ignored.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, RUN, HALT, FAULT};
  - HALT_INSN;
  - opcode constants (OP_BRANCH=7'b1100011, OP_LOAD, OP_STORE, OP_OP, OP_IMM) for reuse by decode.
- One natural sub-module: fetch_out_reg, the valid/ready holding register with flush input. The PC/FSM logic stays in fetch_sequencer.

Test Plan:
- Reset, start, id_ready=1, memory mem[k]=k+1 -> id_pc 0,4,8,… one per cycle; id_instr=1,2,3; issued_cnt matches; i_mem_addr = pc>>2.
- Stall: hold id_ready=0 for 3 cycles at id_pc=8 -> id_instr/id_pc/pc frozen (pc=12). Release -> id_pc=12 next; no drop or duplicate.
- Redirect to 36 while id_pc=24 valid and stalled -> next cycle id_valid=0, pc=36. Following cycle id_pc=36. The flushed instruction is not counted.
- Redirect to 0x22 (misaligned) -> fault=1, id_valid=0, pc frozen. Later start/redirect ignored; rst clears.
- Program ends at mem[14]=32'h00000063, accepted -> halted=1 next cycle, id_valid=0, issued_cnt includes the halt word. Redirect in the same cycle as halt handshake -> no halt, pc=target.
- Wrap: redirect to 252 -> fetch 252, then pc=0. Assert rst mid-stream -> all outputs at reset values next cycle, IDLE until start.
